// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per shift_en tick,
// registered Sout/sout_valid and a one-cycle done pulse; back-to-back words stream gap-free.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             Sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             last;
  logic             accept;

  // load_ready depends combinationally on shift_en so a new word can be taken
  // on the final-bit cycle without an idle gap.
  always_comb begin
    last       = (state_q == SHIFT) && (cnt_q == CNT_LAST) && shift_en;
    load_ready = !rst && ((state_q == IDLE) || last);
    accept     = load_valid && load_ready;

    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (accept) begin
      sreg_d  = Din;
      cnt_d   = '0;
      state_d = SHIFT;
      sout_d  = (MSB_FIRST != 0) ? Din[WIDTH-1] : Din[0];
      valid_d = 1'b1;
      done_d  = last;
    end else if (last) begin
      state_d = IDLE;
      valid_d = 1'b0;
      sout_d  = 1'b0;
      done_d  = 1'b1;
    end else if ((state_q == SHIFT) && shift_en) begin
      cnt_d = cnt_q + CW'(1);
      if (MSB_FIRST != 0) begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        sout_d = sreg_q[WIDTH-2];
      end else begin
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        sout_d = sreg_q[1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Sout       = sout_q;
  assign sout_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus
// and are compared against a word/bits-remaining reference model every cycle.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] Din = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic rdy_m, sout_m, sv_m, busy_m, done_m;
  logic rdy_l, sout_l, sv_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  // Reference model: [0] = MSB-first, [1] = LSB-first.
  logic [W-1:0] m_word[2];
  int           m_left[2];
  logic         m_done[2];

  logic sink_q[$];

  always #5 Clk = ~Clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .Clk(Clk), .rst(rst), .Din(Din), .load_valid(load_valid), .load_ready(rdy_m),
    .shift_en(shift_en), .Sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .Clk(Clk), .rst(rst), .Din(Din), .load_valid(load_valid), .load_ready(rdy_l),
    .shift_en(shift_en), .Sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int i);
    int k;
    if (m_left[i] == 0) return 1'b0;
    k = W - m_left[i];  // position in transmit order
    return (i == 0) ? m_word[i][W-1-k] : m_word[i][k];
  endfunction

  // One clock cycle: drive at negedge, check ready, model edge, check registered outputs.
  task automatic step(input logic r, input logic lv, input logic [W-1:0] d,
                      input logic se, output logic acc);
    logic exp_rdy[2];
    logic cons, dn;
    @(negedge Clk);
    rst = r; load_valid = lv; Din = d; shift_en = se;
    #1;
    for (int i = 0; i < 2; i++)
      exp_rdy[i] = !r && ((m_left[i] == 0) || ((m_left[i] == 1) && se));
    check("load_ready_msb", rdy_m, exp_rdy[0]);
    check("load_ready_lsb", rdy_l, exp_rdy[1]);
    if (se && sv_m) sink_q.push_back(sout_m);
    acc = lv && exp_rdy[0];
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
      end else begin
        cons = (m_left[i] > 0) && se;
        dn   = cons && (m_left[i] == 1);
        if (lv && exp_rdy[i]) begin
          m_word[i] = d;
          m_left[i] = W;
        end else if (cons) begin
          m_left[i]--;
        end
        m_done[i] = dn;
      end
    end
    #1;
    check("sout_msb",  sout_m, exp_bit(0));
    check("valid_msb", sv_m,   m_left[0] > 0);
    check("busy_msb",  busy_m, m_left[0] > 0);
    check("done_msb",  done_m, m_done[0]);
    check("sout_lsb",  sout_l, exp_bit(1));
    check("valid_lsb", sv_l,   m_left[1] > 0);
    check("busy_lsb",  busy_l, m_left[1] > 0);
    check("done_lsb",  done_l, m_done[1]);
  endtask

  task automatic load_word(input logic [W-1:0] d, output int waited);
    logic acc;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      step(1'b0, 1'b1, d, 1'b1, acc);
      waited++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int n, input logic se);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, se, acc);
  endtask

  function automatic logic [W-1:0] sink_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W && i < sink_q.size(); i++) v[W-1-i] = sink_q[i];
    return v;
  endfunction

  initial begin
    logic acc;
    int   waited, n;
    logic [3:0] pat;
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0; m_left[i] = 0; m_done[i] = 1'b0;
    end

    step(1'b1, 1'b1, 8'hFF, 1'b1, acc);
    step(1'b1, 1'b0, '0, 1'b0, acc);

    // MSB/LSB single words (A5 and 01), shift_en held
    sink_q.delete();
    load_word(8'hA5, waited);
    run(10, 1'b1);
    check("msb_word_a5", sink_word(), 8'hA5);
    check("msb_bit_count", sink_q.size(), W);
    load_word(8'h01, waited);
    run(10, 1'b1);

    // back-to-back A5 then 3C
    sink_q.delete();
    load_word(8'hA5, waited);
    load_word(8'h3C, waited);
    check("b2b_gap", waited, 8);
    run(10, 1'b1);
    check("b2b_bits", sink_q.size(), 2 * W);

    // stall pattern on F0
    sink_q.delete();
    load_word(8'hF0, waited);
    pat = 4'b1001;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, (i % 3 == 0) || pat[i % 4], acc);
    check("stall_word_f0", sink_word(), 8'hF0);
    check("stall_bit_count", sink_q.size(), W);

    // load attempt while busy
    load_word(8'h00, waited);
    run(2, 1'b1);
    load_word(8'hFF, waited);
    check("busy_load_delay", waited + 2, 8);
    run(10, 1'b1);

    // reset mid-word, then a clean word
    load_word(8'hA5, waited);
    run(4, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, acc);
    run(1, 1'b0);
    sink_q.delete();
    load_word(8'h3C, waited);
    run(10, 1'b1);
    check("post_reset_3c", sink_word(), 8'h3C);

    // randomized traffic
    n = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, W'($urandom),
           $urandom_range(0, 3) != 0, acc);
      if (acc) n++;
    end
    if (n < 20) check("random_accepts", n, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
